// File: rtl/clksw_sequencer.sv
// clksw_sequencer
// Sequences the PHI2 clock switch from the lsclk_in domain. It raises hsclk_sel
// when the address decode asks for the fast clock, and it confirms every change
// through the switch status feedback. The divider select changes only while the
// LS clock drives the CPU. The block enforces a minimum HS dwell, flags
// handshakes that never complete, and counts completed LS->HS switches.
// Every output comes from a register, so no input reaches an output
// combinationally.
module clksw_sequencer #(
  parameter int SYNC_STAGES = 2,
  parameter int MIN_DWELL   = 4,
  parameter int TIMEOUT     = 64,
  parameter int DIV_SETTLE  = 4,
  parameter int CNT_W       = 8
) (
  input  logic             lsclk_in,
  input  logic             rst_b,
  input  logic             hs_req,
  input  logic             force_ls,
  input  logic [1:0]       div_cfg,
  input  logic             err_clr,
  input  logic             hsclk_selected,
  input  logic             lsclk_selected,
  output logic             hsclk_sel,
  output logic [1:0]       cpuclk_div_sel,
  output logic             in_hs,
  output logic             busy,
  output logic             sw_err,
  output logic [CNT_W-1:0] switch_cnt
);

  localparam int TIMER_W  = $clog2(TIMEOUT + 1);
  localparam int DWELL_W  = $clog2(MIN_DWELL + 1);
  localparam int SETTLE_W = $clog2(DIV_SETTLE + 1);

  localparam logic [TIMER_W-1:0]  TIMER_LAST  = TIMER_W'(TIMEOUT - 1);
  localparam logic [DWELL_W-1:0]  DWELL_MAX   = DWELL_W'(MIN_DWELL);
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(DIV_SETTLE - 1);

  typedef enum logic [2:0] {
    LS_RUN  = 3'd0,
    DIV_UPD = 3'd1,
    TO_HS   = 3'd2,
    HS_RUN  = 3'd3,
    TO_LS   = 3'd4
  } state_t;

  state_t                 state_reg;
  state_t                 state_next;
  logic                   hsclk_sel_reg;
  logic                   hsclk_sel_next;
  logic [1:0]             div_sel_reg;
  logic [1:0]             div_sel_next;
  logic                   sw_err_reg;
  logic                   err_set;
  logic [CNT_W-1:0]       switch_cnt_reg;
  logic                   cnt_inc;
  logic [TIMER_W-1:0]     timer_reg;
  logic [DWELL_W-1:0]     dwell_reg;
  logic [SETTLE_W-1:0]    settle_reg;
  logic [SYNC_STAGES-1:0] sync_reg;
  logic [SYNC_STAGES-1:0] sync_next;
  logic                   hs_sync;
  logic                   hs_ok;
  logic                   ls_ok;
  logic                   state_change;

  genvar gi;

  // The status from the cpuclk domain passes through a plain flop chain.
  // Stage 0 samples the raw input, and every later stage takes the one before it.
  generate
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      if (gi == 0) begin : g_first
        assign sync_next[gi] = hsclk_selected;
      end else begin : g_rest
        assign sync_next[gi] = sync_reg[gi-1];
      end
    end
  endgenerate

  // Synchroniser shift register for hsclk_selected.
  always_ff @(posedge lsclk_in or negedge rst_b) begin
    if (!rst_b) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= sync_next;
    end
  end

  assign hs_sync      = sync_reg[SYNC_STAGES-1];
  assign hs_ok        = hs_sync & ~lsclk_selected;
  assign ls_ok        = ~hs_sync & lsclk_selected;
  assign state_change = (state_next != state_reg);

  // State register plus the registered switch request and divider select.
  always_ff @(posedge lsclk_in or negedge rst_b) begin
    if (!rst_b) begin
      state_reg     <= LS_RUN;
      hsclk_sel_reg <= 1'b0;
      div_sel_reg   <= 2'b00;
    end else begin
      state_reg     <= state_next;
      hsclk_sel_reg <= hsclk_sel_next;
      div_sel_reg   <= div_sel_next;
    end
  end

  // Next-state logic. hsclk_sel tracks the state: it is 1 in TO_HS and HS_RUN.
  always_comb begin
    state_next     = state_reg;
    hsclk_sel_next = hsclk_sel_reg;
    div_sel_next   = div_sel_reg;
    err_set        = 1'b0;
    cnt_inc        = 1'b0;
    case (state_reg)
      LS_RUN: begin
        // A pending divider change goes first, so a switch never starts on a stale divider.
        if (div_cfg != div_sel_reg) begin
          div_sel_next = div_cfg;
          state_next   = DIV_UPD;
        end else if (hs_req && !force_ls && lsclk_selected) begin
          hsclk_sel_next = 1'b1;
          state_next     = TO_HS;
        end
      end
      DIV_UPD: begin
        if (settle_reg == SETTLE_LAST) begin
          state_next = LS_RUN;
        end
      end
      TO_HS: begin
        if (force_ls || !hs_req) begin
          hsclk_sel_next = 1'b0;
          state_next     = TO_LS;
        end else if (hs_ok) begin
          state_next = HS_RUN;
          cnt_inc    = 1'b1;
        end else if (timer_reg == TIMER_LAST) begin
          err_set        = 1'b1;
          hsclk_sel_next = 1'b0;
          state_next     = TO_LS;
        end
      end
      HS_RUN: begin
        if (force_ls || (!hs_req && (dwell_reg >= DWELL_MAX))) begin
          hsclk_sel_next = 1'b0;
          state_next     = TO_LS;
        end
      end
      TO_LS: begin
        // With no ls_ok, stay here and keep flagging once the timer saturates.
        if (ls_ok) begin
          state_next = LS_RUN;
        end else if (timer_reg == TIMER_LAST) begin
          err_set = 1'b1;
        end
      end
      default: begin
        hsclk_sel_next = 1'b0;
        state_next     = LS_RUN;
      end
    endcase
  end

  // Per-state counters. All of them clear on any state entry and saturate at their limit.
  always_ff @(posedge lsclk_in or negedge rst_b) begin
    if (!rst_b) begin
      timer_reg  <= '0;
      dwell_reg  <= '0;
      settle_reg <= '0;
    end else if (state_change) begin
      timer_reg  <= '0;
      dwell_reg  <= '0;
      settle_reg <= '0;
    end else begin
      if (((state_reg == TO_HS) || (state_reg == TO_LS)) && (timer_reg != TIMER_LAST)) begin
        timer_reg <= timer_reg + TIMER_W'(1);
      end
      if ((state_reg == HS_RUN) && (dwell_reg != DWELL_MAX)) begin
        dwell_reg <= dwell_reg + DWELL_W'(1);
      end
      if ((state_reg == DIV_UPD) && (settle_reg != SETTLE_LAST)) begin
        settle_reg <= settle_reg + SETTLE_W'(1);
      end
    end
  end

  // Sticky timeout flag. A timeout in the same cycle as err_clr keeps the flag set.
  always_ff @(posedge lsclk_in or negedge rst_b) begin
    if (!rst_b) begin
      sw_err_reg <= 1'b0;
    end else if (err_set) begin
      sw_err_reg <= 1'b1;
    end else if (err_clr) begin
      sw_err_reg <= 1'b0;
    end
  end

  // Completed LS->HS switch counter, wrapping modulo 2^CNT_W.
  always_ff @(posedge lsclk_in or negedge rst_b) begin
    if (!rst_b) begin
      switch_cnt_reg <= '0;
    end else if (cnt_inc) begin
      switch_cnt_reg <= switch_cnt_reg + CNT_W'(1);
    end
  end

  assign hsclk_sel      = hsclk_sel_reg;
  assign cpuclk_div_sel = div_sel_reg;
  assign in_hs          = (state_reg == HS_RUN);
  assign busy           = (state_reg == TO_HS) || (state_reg == TO_LS) || (state_reg == DIV_UPD);
  assign sw_err         = sw_err_reg;
  assign switch_cnt     = switch_cnt_reg;

endmodule

// File: tb/tb_clksw_sequencer.sv
// tb_clksw_sequencer
// Random stimulus drives the sequencer. A behavioural clock-switch model
// answers its requests. The driver predicts the outputs after each clock edge
// from a reference model and queues the prediction. A separate monitor pops
// each prediction and compares it after the edge.
module tb_clksw_sequencer;

  localparam int SYNC_STAGES = 2;
  localparam int MIN_DWELL   = 4;
  localparam int TIMEOUT     = 64;
  localparam int DIV_SETTLE  = 4;
  localparam int CNT_W       = 8;
  localparam int NCYC        = 6000;
  localparam int RST_AT      = 3000;

  localparam int M_LS   = 0;
  localparam int M_DIV  = 1;
  localparam int M_TOHS = 2;
  localparam int M_HS   = 3;
  localparam int M_TOLS = 4;

  typedef struct packed {
    logic             hs;
    logic [1:0]       div;
    logic             in_hs;
    logic             busy;
    logic             err;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  logic             lsclk_in = 1'b0;
  logic             rst_b = 1'b0;
  logic             hs_req = 1'b0;
  logic             force_ls = 1'b0;
  logic [1:0]       div_cfg = 2'b00;
  logic             err_clr = 1'b0;
  logic             hsclk_selected = 1'b0;
  logic             lsclk_selected = 1'b1;
  logic             hsclk_sel;
  logic [1:0]       cpuclk_div_sel;
  logic             in_hs;
  logic             busy;
  logic             sw_err;
  logic [CNT_W-1:0] switch_cnt;

  int   checks = 0;
  int   failures = 0;
  exp_t exp_q[$];

  // Reference model: a mode, the number of cycles spent in that mode, and the visible registers.
  int         m_mode = M_LS;
  int         m_age = 0;
  logic [1:0] m_div = 2'b00;
  logic       m_err = 1'b0;
  int         m_cnt = 0;
  int         m_cyc = 0;
  logic       hs_hist[$];

  // Clock-switch model.
  logic sw_hs = 1'b0;
  logic sw_ls = 1'b1;
  int   sw_delay = 2;
  logic stuck = 1'b0;

  always #5 lsclk_in = ~lsclk_in;

  clksw_sequencer #(
    .SYNC_STAGES(SYNC_STAGES),
    .MIN_DWELL  (MIN_DWELL),
    .TIMEOUT    (TIMEOUT),
    .DIV_SETTLE (DIV_SETTLE),
    .CNT_W      (CNT_W)
  ) dut (
    .lsclk_in      (lsclk_in),
    .rst_b         (rst_b),
    .hs_req        (hs_req),
    .force_ls      (force_ls),
    .div_cfg       (div_cfg),
    .err_clr       (err_clr),
    .hsclk_selected(hsclk_selected),
    .lsclk_selected(lsclk_selected),
    .hsclk_sel     (hsclk_sel),
    .cpuclk_div_sel(cpuclk_div_sel),
    .in_hs         (in_hs),
    .busy          (busy),
    .sw_err        (sw_err),
    .switch_cnt    (switch_cnt)
  );

  function automatic string mode_name(int m);
    case (m)
      M_LS:    return "LS_RUN";
      M_DIV:   return "DIV_UPD";
      M_TOHS:  return "TO_HS";
      M_HS:    return "HS_RUN";
      default: return "TO_LS";
    endcase
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    e.hs    = (m_mode == M_TOHS) || (m_mode == M_HS);
    e.div   = m_div;
    e.in_hs = (m_mode == M_HS);
    e.busy  = (m_mode == M_TOHS) || (m_mode == M_TOLS) || (m_mode == M_DIV);
    e.err   = m_err;
    e.cnt   = CNT_W'(m_cnt);
    return e;
  endfunction

  task automatic model_reset();
    m_mode = M_LS;
    m_age  = 0;
    m_div  = 2'b00;
    m_err  = 1'b0;
    m_cnt  = 0;
    hs_hist.delete();
    for (int i = 0; i < SYNC_STAGES; i++) hs_hist.push_back(1'b0);
  endtask

  // Advances the model by one clock edge, using the inputs as they stand now.
  task automatic model_step();
    logic sync_hs;
    logic hs_ok;
    logic ls_ok;
    logic set_err;
    int   nmode;
    sync_hs = hs_hist[0];
    hs_hist.push_back(hsclk_selected);
    void'(hs_hist.pop_front());
    hs_ok   = sync_hs && !lsclk_selected;
    ls_ok   = !sync_hs && lsclk_selected;
    set_err = 1'b0;
    nmode   = m_mode;
    case (m_mode)
      M_LS: begin
        if (div_cfg != m_div) begin
          m_div = div_cfg;
          nmode = M_DIV;
        end else if (hs_req && !force_ls && lsclk_selected) begin
          nmode = M_TOHS;
        end
      end
      M_DIV:  if (m_age == DIV_SETTLE - 1) nmode = M_LS;
      M_TOHS: begin
        if (force_ls || !hs_req) nmode = M_TOLS;
        else if (hs_ok) begin
          nmode = M_HS;
          m_cnt = (m_cnt + 1) % (1 << CNT_W);
        end else if (m_age == TIMEOUT - 1) begin
          set_err = 1'b1;
          nmode   = M_TOLS;
        end
      end
      M_HS: if (force_ls || (!hs_req && m_age >= MIN_DWELL)) nmode = M_TOLS;
      default: begin
        if (ls_ok) nmode = M_LS;
        else if (m_age >= TIMEOUT - 1) set_err = 1'b1;
      end
    endcase
    if (set_err) m_err = 1'b1;
    else if (err_clr) m_err = 1'b0;
    if (nmode != m_mode) begin
      $display("txn cyc=%0d %s -> %s div=%b cnt=%0d err=%0d", m_cyc, mode_name(m_mode),
               mode_name(nmode), m_div, m_cnt, m_err);
      m_mode = nmode;
      m_age  = 0;
    end else if (m_age < 1000000) begin
      m_age = m_age + 1;
    end
  endtask

  // The switch follows the requested clock after a random delay. On the way to HS it drops
  // LS first (break before make). While stuck, it ignores every request.
  task automatic switch_update();
    logic tgt;
    tgt = (m_mode == M_TOHS) || (m_mode == M_HS);
    if (sw_hs == tgt && sw_ls == !tgt) begin
      sw_delay = $urandom_range(5, 1);
    end else if (!stuck) begin
      if (sw_delay == 0) begin
        sw_hs = tgt;
        sw_ls = !tgt;
      end else begin
        if (tgt) sw_ls = 1'b0;
        sw_delay = sw_delay - 1;
      end
    end
  endtask

  // Driver: sets the inputs at the negedge and queues the outputs expected after the next posedge.
  initial begin : driver
    int   flip_div;
    int   seg_left;
    exp_t got;
    model_reset();
    repeat (3) @(posedge lsclk_in);
    #1;
    got = '{hs: hsclk_sel, div: cpuclk_div_sel, in_hs: in_hs, busy: busy, err: sw_err, cnt: switch_cnt};
    checks++;
    if (got !== model_out()) begin
      failures++;
      $display("FAIL reset_state got=%h expected=%h", got, model_out());
    end
    @(negedge lsclk_in);
    rst_b    = 1'b1;
    flip_div = 16;
    seg_left = 0;
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      if (cyc > 0) @(negedge lsclk_in);
      m_cyc = cyc;
      switch_update();
      if (seg_left == 0) begin
        seg_left = $urandom_range(300, 50);
        stuck    = ($urandom_range(2, 0) == 0);
        case ($urandom_range(2, 0))
          0:       flip_div = 8;
          1:       flip_div = 32;
          default: flip_div = 160;
        endcase
      end
      seg_left = seg_left - 1;
      if (cyc == 0) begin
        div_cfg = 2'b10;
        hs_req  = 1'b1;
      end else begin
        if ($urandom_range(flip_div - 1, 0) == 0) hs_req = !hs_req;
        force_ls = ($urandom_range(39, 0) == 0);
        err_clr  = ($urandom_range(29, 0) == 0);
        if ($urandom_range(49, 0) == 0) div_cfg = 2'($urandom_range(3, 0));
      end
      hsclk_selected = sw_hs;
      lsclk_selected = sw_ls;
      if (cyc >= RST_AT && cyc < RST_AT + 3) begin
        rst_b = 1'b0;
        model_reset();
        exp_q.push_back(model_out());
      end else begin
        rst_b = 1'b1;
        model_step();
        exp_q.push_back(model_out());
      end
    end
    @(posedge lsclk_in);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d expected=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Monitor: compares the DUT against the oldest prediction shortly after each posedge.
  initial begin : monitor
    exp_t e;
    exp_t got;
    forever begin
      @(posedge lsclk_in);
      #1;
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        got = '{hs: hsclk_sel, div: cpuclk_div_sel, in_hs: in_hs, busy: busy, err: sw_err, cnt: switch_cnt};
        checks++;
        if (got !== e) begin
          failures++;
          $display("FAIL outputs t=%0t got hs=%b div=%b in_hs=%b busy=%b err=%b cnt=%0d expected hs=%b div=%b in_hs=%b busy=%b err=%b cnt=%0d",
                   $time, got.hs, got.div, got.in_hs, got.busy, got.err, got.cnt,
                   e.hs, e.div, e.in_hs, e.busy, e.err, e.cnt);
        end
      end
    end
  end

endmodule
